// File: rtl/rect_sprite_engine.sv
// rect_sprite_engine: N_RECT bouncing solid rectangles composited over a
// background colour, placed between the VGA timing generator and the pins.
// Ports: clk, rst (synchronous, active-high), frame_tick, active,
//   curr_x/curr_y (scan position), rect_en, rect_color ({b,g,r} per rect),
//   pos_wr/pos_idx/pos_x/pos_y (host position write),
//   pix_r/pix_g/pix_b and active_out (2 clk after curr_*), collide.
// Optional feature: define RECT_COLLIDE_EN to build the overlap detector;
//   without it collide is tied to 0.
module rect_sprite_engine #(
    parameter int          N_RECT   = 4,
    parameter int          H_ACTIVE = 1440,
    parameter int          V_ACTIVE = 900,
    parameter int          X_W      = 11,
    parameter int          Y_W      = 10,
    parameter int          RECT_W   = 64,
    parameter int          RECT_H   = 48,
    parameter int          STEP     = 2,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 active,
    input  logic [X_W-1:0]       curr_x,
    input  logic [Y_W-1:0]       curr_y,
    input  logic [N_RECT-1:0]    rect_en,
    input  logic [12*N_RECT-1:0] rect_color,
    input  logic                 pos_wr,
    input  logic [2:0]           pos_idx,
    input  logic [X_W-1:0]       pos_x,
    input  logic [Y_W-1:0]       pos_y,
    output logic [3:0]           pix_r,
    output logic [3:0]           pix_g,
    output logic [3:0]           pix_b,
    output logic                 active_out,
    output logic                 collide
);

    localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE - RECT_W);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_ACTIVE - RECT_H);
    localparam logic [X_W-1:0] X_STEP = X_W'(STEP);
    localparam logic [Y_W-1:0] Y_STEP = Y_W'(STEP);
    localparam logic [X_W-1:0] X_SIZE = X_W'(RECT_W);
    localparam logic [Y_W-1:0] Y_SIZE = Y_W'(RECT_H);

    // Position and direction state; a set *_neg bit means moving toward 0.
    logic [X_W-1:0]    x_q [N_RECT];
    logic [Y_W-1:0]    y_q [N_RECT];
    logic [X_W-1:0]    x_d [N_RECT];
    logic [Y_W-1:0]    y_d [N_RECT];
    logic [N_RECT-1:0] dx_neg_q, dy_neg_q;
    logic [N_RECT-1:0] dx_neg_d, dy_neg_d;

    // Pixel pipeline
    logic [N_RECT-1:0] hit_d, hit_q;
    logic              active_q;
    logic [11:0]       pix_d, pix_q;

    // Next position: a host write wins over the frame step.
    always_comb begin
        for (int i = 0; i < N_RECT; i++) begin
            x_d[i]      = x_q[i];
            y_d[i]      = y_q[i];
            dx_neg_d[i] = dx_neg_q[i];
            dy_neg_d[i] = dy_neg_q[i];
            if (pos_wr && int'(pos_idx) == i) begin
                x_d[i] = (pos_x > X_MAX) ? X_MAX : pos_x;
                y_d[i] = (pos_y > Y_MAX) ? Y_MAX : pos_y;
            end else if (frame_tick && rect_en[i]) begin
                if (!dx_neg_q[i]) begin
                    // One extra bit so the sum cannot wrap.
                    if (({1'b0, x_q[i]} + {1'b0, X_STEP}) > {1'b0, X_MAX}) begin
                        x_d[i]      = X_MAX;
                        dx_neg_d[i] = 1'b1;
                    end else begin
                        x_d[i] = x_q[i] + X_STEP;
                    end
                end else if (x_q[i] < X_STEP) begin
                    x_d[i]      = '0;
                    dx_neg_d[i] = 1'b0;
                end else begin
                    x_d[i] = x_q[i] - X_STEP;
                end
                if (!dy_neg_q[i]) begin
                    if (({1'b0, y_q[i]} + {1'b0, Y_STEP}) > {1'b0, Y_MAX}) begin
                        y_d[i]      = Y_MAX;
                        dy_neg_d[i] = 1'b1;
                    end else begin
                        y_d[i] = y_q[i] + Y_STEP;
                    end
                end else if (y_q[i] < Y_STEP) begin
                    y_d[i]      = '0;
                    dy_neg_d[i] = 1'b0;
                end else begin
                    y_d[i] = y_q[i] - Y_STEP;
                end
            end
        end
    end

    // Stage 1 compare: left/top inclusive, right/bottom exclusive.
    always_comb begin
        for (int i = 0; i < N_RECT; i++) begin
            hit_d[i] = rect_en[i] & active
                     & (curr_x >= x_q[i])
                     & ({1'b0, curr_x} < ({1'b0, x_q[i]} + {1'b0, X_SIZE}))
                     & (curr_y >= y_q[i])
                     & ({1'b0, curr_y} < ({1'b0, y_q[i]} + {1'b0, Y_SIZE}));
        end
    end

    // Stage 2 compositing: walk high to low so index 0 ends up on top.
    always_comb begin
        pix_d = active_q ? BG_COLOR : 12'h000;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                pix_d = rect_color[i*12 +: 12];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RECT; i++) begin
                x_q[i] <= X_W'(i * 128);
                y_q[i] <= Y_W'(i * 96);
            end
            dx_neg_q   <= '0;
            dy_neg_q   <= '0;
            hit_q      <= '0;
            active_q   <= 1'b0;
            pix_q      <= '0;
            active_out <= 1'b0;
        end else begin
            for (int i = 0; i < N_RECT; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            dx_neg_q   <= dx_neg_d;
            dy_neg_q   <= dy_neg_d;
            hit_q      <= hit_d;
            active_q   <= active;
            pix_q      <= pix_d;
            active_out <= active_q;
        end
    end

    assign pix_r = pix_q[3:0];
    assign pix_g = pix_q[7:4];
    assign pix_b = pix_q[11:8];

`ifdef RECT_COLLIDE_EN
    logic [3:0] n_hit;
    logic       multi_hit;
    logic       latch_q;
    logic       collide_q;

    always_comb begin
        n_hit = '0;
        for (int i = 0; i < N_RECT; i++) begin
            n_hit = n_hit + 4'(hit_d[i]);
        end
        multi_hit = (n_hit > 4'd1);
    end

    // The latch reloads on frame_tick so an overlap in the tick cycle
    // itself is counted towards the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q   <= 1'b0;
            collide_q <= 1'b0;
        end else if (frame_tick) begin
            collide_q <= latch_q;
            latch_q   <= multi_hit;
        end else if (multi_hit) begin
            latch_q <= 1'b1;
        end
    end

    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_rect_sprite_engine.sv
// Testbench for rect_sprite_engine: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_rect_sprite_engine;

    localparam int N    = 4;
    localparam int HA   = 1440;
    localparam int VA   = 900;
    localparam int RW   = 64;
    localparam int RH   = 48;
    localparam int STEP = 2;
    localparam logic [11:0] BG = 12'h000;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_tick;
    logic          active;
    logic [10:0]   curr_x;
    logic [9:0]    curr_y;
    logic [N-1:0]  rect_en;
    logic [47:0]   rect_color;
    logic          pos_wr;
    logic [2:0]    pos_idx;
    logic [10:0]   pos_x;
    logic [9:0]    pos_y;
    logic [3:0]    pix_r, pix_g, pix_b;
    logic          active_out;
    logic          collide;

    int errors = 0;
    int checks = 0;

    rect_sprite_engine dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .active(active),
        .curr_x(curr_x), .curr_y(curr_y), .rect_en(rect_en),
        .rect_color(rect_color), .pos_wr(pos_wr), .pos_idx(pos_idx),
        .pos_x(pos_x), .pos_y(pos_y), .pix_r(pix_r), .pix_g(pix_g),
        .pix_b(pix_b), .active_out(active_out), .collide(collide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Behavioural model
    int          mx [N];
    int          my [N];
    bit          mdxn [N];
    bit          mdyn [N];
    bit [N-1:0]  mhit1;
    bit          mact1;
    logic [11:0] mpix;
    bit          mactout;
    bit          mlatch;
    bit          mcollide;
    bit          mvalid = 1'b0;

    function automatic void bounce(inout int p, inout bit neg, input int maxv);
        if (!neg) begin
            if (p + STEP > maxv) begin
                p   = maxv;
                neg = 1'b1;
            end else begin
                p = p + STEP;
            end
        end else if (p < STEP) begin
            p   = 0;
            neg = 1'b0;
        end else begin
            p = p - STEP;
        end
    endfunction

    always @(posedge clk) begin : model
        logic [11:0] np;
        bit [N-1:0]  hn;
        int          nh;
        int          p;
        bit          n;
        bit          found;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mx[i] = i * 128;
                my[i] = i * 96;
                mdxn[i] = 1'b0;
                mdyn[i] = 1'b0;
            end
            mhit1 = '0; mact1 = 1'b0; mpix = '0; mactout = 1'b0;
            mlatch = 1'b0; mcollide = 1'b0; mvalid = 1'b1;
        end else begin
            np = mact1 ? BG : 12'h000;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (mhit1[i] && !found) begin
                    np = rect_color[i*12 +: 12];
                    found = 1'b1;
                end
            end
            nh = 0;
            for (int i = 0; i < N; i++) begin
                hn[i] = rect_en[i] && active
                     && int'(curr_x) >= mx[i] && int'(curr_x) < mx[i] + RW
                     && int'(curr_y) >= my[i] && int'(curr_y) < my[i] + RH;
                nh += int'(hn[i]);
            end
`ifdef RECT_COLLIDE_EN
            if (frame_tick) begin
                mcollide = mlatch;
                mlatch = (nh >= 2);
            end else if (nh >= 2) begin
                mlatch = 1'b1;
            end
`endif
            mpix = np;
            mactout = mact1;
            mhit1 = hn;
            mact1 = active;
            for (int i = 0; i < N; i++) begin
                if (pos_wr && int'(pos_idx) == i) begin
                    mx[i] = (int'(pos_x) > HA - RW) ? HA - RW : int'(pos_x);
                    my[i] = (int'(pos_y) > VA - RH) ? VA - RH : int'(pos_y);
                end else if (frame_tick && rect_en[i]) begin
                    p = mx[i]; n = mdxn[i];
                    bounce(p, n, HA - RW);
                    mx[i] = p; mdxn[i] = n;
                    p = my[i]; n = mdyn[i];
                    bounce(p, n, VA - RH);
                    my[i] = p; mdyn[i] = n;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("pix", 32'({pix_b, pix_g, pix_r}), 32'(mpix));
            chk("active_out", 32'(active_out), 32'(mactout));
            chk("collide", 32'(collide), 32'(mcollide));
            for (int i = 0; i < N; i++) begin
                chk("pos_x", 32'(dut.x_q[i]), 32'(mx[i]));
                chk("pos_y", 32'(dut.y_q[i]), 32'(my[i]));
            end
        end
    end

    task automatic px(input int x, input int y, input bit a);
        curr_x = 11'(x);
        curr_y = 10'(y);
        active = a;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input int idx, input int x, input int y);
        pos_wr = 1'b1;
        pos_idx = 3'(idx);
        pos_x = 11'(x);
        pos_y = 10'(y);
        @(negedge clk);
        pos_wr = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    logic [11:0] pix_all;
    assign pix_all = {pix_b, pix_g, pix_r};

    initial begin
        rst = 1'b1; frame_tick = 1'b0; active = 1'b0;
        curr_x = '0; curr_y = '0; rect_en = '1;
        rect_color = {12'h888, 12'hF00, 12'h0F0, 12'h00F};
        pos_wr = 1'b0; pos_idx = '0; pos_x = '0; pos_y = '0;
        repeat (2) @(negedge clk);
        chk("rst_pix", 32'(pix_all), 32'h0);
        chk("rst_active_out", 32'(active_out), 32'h0);
        chk("rst_collide", 32'(collide), 32'h0);
        rst = 1'b0;

        // Rect 0 edges, background, blanking
        px(0, 0, 1'b1);   chk("t1_origin", 32'(pix_all), 32'h00F);
        px(63, 47, 1'b1); chk("t1_corner", 32'(pix_all), 32'h00F);
        px(64, 0, 1'b1);  chk("t1_right_excl", 32'(pix_all), 32'(BG));
        chk("t1_active_out", 32'(active_out), 32'h1);
        px(10, 10, 1'b0); chk("t1_blank", 32'(pix_all), 32'h0);

        // Priority
        wr(1, 0, 0);
        px(10, 10, 1'b1); chk("t2_priority", 32'(pix_all), 32'h00F);
        rect_en[0] = 1'b0;
        px(10, 10, 1'b1); chk("t2_rect1", 32'(pix_all), 32'h0F0);
        rect_en[0] = 1'b1;

        // Right wall bounce and clamp
        wr(0, 1375, 0);
        tick();
        chk("t3_wall_x", 32'(dut.x_q[0]), 32'd1376);
        chk("t3_wall_dir", 32'(dut.dx_neg_q[0]), 32'h1);
        tick();
        chk("t3_back_x", 32'(dut.x_q[0]), 32'd1374);
        wr(0, 2000, 0);
        chk("t3_clamp_x", 32'(dut.x_q[0]), 32'd1376);

        // Left wall bounce, disabled rect holds
        wr(0, 1, 0);
        tick();
        chk("t4_left_x", 32'(dut.x_q[0]), 32'd0);
        chk("t4_left_dir", 32'(dut.dx_neg_q[0]), 32'h0);
        tick();
        chk("t4_next_x", 32'(dut.x_q[0]), 32'd2);
        rect_en[3] = 1'b0;
        tick();
        chk("t4_hold_x", 32'(dut.x_q[3]), 32'd392);
        chk("t4_hold_y", 32'(dut.y_q[3]), 32'd296);
        rect_en[3] = 1'b1;

        // Write and tick in the same cycle
        pos_wr = 1'b1; pos_idx = 3'd2; pos_x = 11'd100; pos_y = 10'd100;
        frame_tick = 1'b1;
        @(negedge clk);
        pos_wr = 1'b0; frame_tick = 1'b0;
        chk("t5_wr_x", 32'(dut.x_q[2]), 32'd100);
        chk("t5_wr_y", 32'(dut.y_q[2]), 32'd100);
        chk("t5_step_x", 32'(dut.x_q[0]), 32'd6);
        chk("t5_step_y", 32'(dut.y_q[0]), 32'd8);

        // Reset mid-line
        px(7, 9, 1'b1);
        chk("t5_pre_rst", 32'(pix_all), 32'h00F);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_pix", 32'(pix_all), 32'h0);
        chk("t5_rst_act", 32'(active_out), 32'h0);
        chk("t5_rst_col", 32'(collide), 32'h0);
        chk("t5_rst_x1", 32'(dut.x_q[1]), 32'd128);
        chk("t5_rst_y3", 32'(dut.y_q[3]), 32'd288);

        // Overlap frame then clean frame
        wr(1, 10, 10);
        for (int yy = 10; yy < 13; yy++)
            for (int xx = 10; xx < 21; xx++) begin
                curr_x = 11'(xx); curr_y = 10'(yy); active = 1'b1;
                @(negedge clk);
            end
        active = 1'b0;
        repeat (2) @(negedge clk);
        tick();
`ifdef RECT_COLLIDE_EN
        chk("t6_collide_set", 32'(collide), 32'h1);
`else
        chk("t6_collide_off", 32'(collide), 32'h0);
`endif
        for (int yy = 2; yy < 5; yy++)
            for (int xx = 2; xx < 8; xx++) begin
                curr_x = 11'(xx); curr_y = 10'(yy); active = 1'b1;
                @(negedge clk);
            end
        active = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        chk("t6_collide_clear", 32'(collide), 32'h0);

        // Randomized traffic aimed around the rectangles
        for (int k = 0; k < 4000; k++) begin
            int r;
            r = $urandom_range(0, N - 1);
            rst = ($urandom_range(0, 299) == 0);
            frame_tick = ($urandom_range(0, 24) == 0);
            pos_wr = ($urandom_range(0, 15) == 0);
            pos_idx = 3'($urandom_range(0, 7));
            pos_x = 11'($urandom);
            pos_y = 10'($urandom);
            if ($urandom_range(0, 63) == 0) rect_en = 4'($urandom);
            if ($urandom_range(0, 127) == 0)
                rect_color = 48'({$urandom, $urandom});
            active = ($urandom_range(0, 7) != 0);
            curr_x = 11'(mx[r] + int'($urandom_range(0, RW + 8)) - 4);
            curr_y = 10'(my[r] + int'($urandom_range(0, RH + 8)) - 4);
            @(negedge clk);
        end
        rst = 1'b0;
        frame_tick = 1'b0;
        pos_wr = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
